// File: rtl/display_timing_generator_pkg.sv
// Shared types, default 640x480@60 timing and helpers for the display timing generator.
package display_timing_pkg;

  typedef enum logic [2:0] {
    SYNC,
    BP,
    BORDER_LT,
    ADDR,
    BORDER_RB,
    FP
  } axis_state_e;

  localparam int unsigned DEF_H_SYNC = 96;
  localparam int unsigned DEF_H_BP   = 40;
  localparam int unsigned DEF_H_LB   = 8;
  localparam int unsigned DEF_H_ADDR = 640;
  localparam int unsigned DEF_H_RB   = 8;
  localparam int unsigned DEF_H_FP   = 8;
  localparam int unsigned DEF_V_SYNC = 2;
  localparam int unsigned DEF_V_BP   = 25;
  localparam int unsigned DEF_V_TB   = 8;
  localparam int unsigned DEF_V_ADDR = 480;
  localparam int unsigned DEF_V_BB   = 8;
  localparam int unsigned DEF_V_FP   = 2;

  function automatic int unsigned axis_total(input int unsigned s, input int unsigned bp,
                                             input int unsigned lt, input int unsigned ad,
                                             input int unsigned rb, input int unsigned fp);
    return s + bp + lt + ad + rb + fp;
  endfunction

  // Segment holding a position; zero-length segments are never returned.
  function automatic axis_state_e axis_seg(input int unsigned pos, input int unsigned s,
                                           input int unsigned bp, input int unsigned lt,
                                           input int unsigned ad, input int unsigned rb);
    if (pos < s)                     return SYNC;
    if (pos < s + bp)                return BP;
    if (pos < s + bp + lt)           return BORDER_LT;
    if (pos < s + bp + lt + ad)      return ADDR;
    if (pos < s + bp + lt + ad + rb) return BORDER_RB;
    return FP;
  endfunction

endpackage

// File: rtl/display_timing_generator_timing_axis.sv
// One raster axis: position counter with clear/advance, segment state, and lookahead flags.
module timing_axis
  import display_timing_pkg::*;
#(
  parameter int unsigned CW       = 11,
  parameter int unsigned SYNC_LEN = 96,
  parameter int unsigned BP_LEN   = 40,
  parameter int unsigned LT_LEN   = 8,
  parameter int unsigned ADDR_LEN = 640,
  parameter int unsigned RB_LEN   = 8,
  parameter int unsigned FP_LEN   = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_en,
  input  logic          i_clr,
  output logic [CW-1:0] o_cnt,
  output logic [CW-1:0] o_cnt_nxt_c,
  output axis_state_e   o_state_nxt_c,
  output logic          o_sync_c,
  output logic          o_active_c,
  output logic          o_wrap_c
);

  localparam int unsigned TOTAL = axis_total(SYNC_LEN, BP_LEN, LT_LEN, ADDR_LEN, RB_LEN, FP_LEN);
  localparam logic [CW-1:0] LAST = CW'(TOTAL - 1);
  localparam axis_state_e ZERO_STATE = axis_seg(0, SYNC_LEN, BP_LEN, LT_LEN, ADDR_LEN, RB_LEN);

  logic [CW-1:0] r_cnt;
  axis_state_e   r_state;
  logic [CW-1:0] w_cnt_nxt;
  axis_state_e   w_state_nxt;
  logic          w_wrap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_state <= ZERO_STATE;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_state <= w_state_nxt;
    end
  end

  // Clear beats advance; terminal count wraps to zero.
  always_comb begin
    w_cnt_nxt   = r_cnt;
    w_state_nxt = r_state;
    w_wrap      = 1'b0;
    if (i_clr) begin
      w_cnt_nxt   = '0;
      w_state_nxt = ZERO_STATE;
    end else if (i_en) begin
      if (r_cnt == LAST) begin
        w_cnt_nxt   = '0;
        w_state_nxt = ZERO_STATE;
        w_wrap      = 1'b1;
      end else begin
        w_cnt_nxt   = r_cnt + CW'(1);
        w_state_nxt = axis_seg(32'(r_cnt) + 32'd1, SYNC_LEN, BP_LEN, LT_LEN, ADDR_LEN, RB_LEN);
      end
    end
  end

  assign o_cnt         = r_cnt;
  assign o_cnt_nxt_c   = w_cnt_nxt;
  assign o_state_nxt_c = w_state_nxt;
  assign o_sync_c      = (w_state_nxt == SYNC);
  assign o_active_c    = (w_state_nxt == ADDR);
  assign o_wrap_c      = w_wrap;

endmodule

// File: rtl/display_timing_generator.sv
// Parametrised VGA/DVI raster timing generator with fetch lookahead and frame restart.
// Optional frame_count output enabled by defining DISPLAY_TIMING_FRAME_CNT_EN.
module display_timing_generator
  import display_timing_pkg::*;
#(
  parameter int unsigned CW         = 11,
  parameter int unsigned H_SYNC     = DEF_H_SYNC,
  parameter int unsigned H_BP       = DEF_H_BP,
  parameter int unsigned H_LB       = DEF_H_LB,
  parameter int unsigned H_ADDR     = DEF_H_ADDR,
  parameter int unsigned H_RB       = DEF_H_RB,
  parameter int unsigned H_FP       = DEF_H_FP,
  parameter int unsigned V_SYNC     = DEF_V_SYNC,
  parameter int unsigned V_BP       = DEF_V_BP,
  parameter int unsigned V_TB       = DEF_V_TB,
  parameter int unsigned V_ADDR     = DEF_V_ADDR,
  parameter int unsigned V_BB       = DEF_V_BB,
  parameter int unsigned V_FP       = DEF_V_FP,
  parameter logic        HS_POL     = 1'b0,
  parameter logic        VS_POL     = 1'b0,
  parameter int unsigned FETCH_LEAD = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          restart,
  output logic          hs,
  output logic          vs,
  output logic          de,
  output logic          border,
  output logic          fetch_en,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
  output logic          frame_start
`ifdef DISPLAY_TIMING_FRAME_CNT_EN
  ,
  output logic [15:0]   frame_count
`endif
);

  localparam int unsigned H_TOTAL = axis_total(H_SYNC, H_BP, H_LB, H_ADDR, H_RB, H_FP);
  localparam int unsigned V_TOTAL = axis_total(V_SYNC, V_BP, V_TB, V_ADDR, V_BB, V_FP);
  localparam int unsigned HA      = H_SYNC + H_BP + H_LB;
  localparam int unsigned VA      = V_SYNC + V_BP + V_TB;
  localparam int unsigned F_START = HA - FETCH_LEAD;
  localparam int unsigned F_END   = F_START + H_ADDR;

  if ($clog2(H_TOTAL) > int'(CW) || $clog2(V_TOTAL) > int'(CW)) begin : g_err_cw
    $error("display_timing_generator: CW too narrow for H_TOTAL/V_TOTAL");
  end
  if (FETCH_LEAD > HA) begin : g_err_lead
    $error("display_timing_generator: FETCH_LEAD exceeds H_SYNC+H_BP+H_LB");
  end

  logic [CW-1:0] w_h_cnt, w_h_nxt, w_v_cnt, w_v_nxt;
  axis_state_e   w_h_state, w_v_state;
  logic          w_h_sync, w_v_sync, w_h_act, w_v_act, w_h_wrap, w_v_wrap;
  logic          w_h_vis, w_v_vis, w_de, w_border, w_fetch;
  logic [CW-1:0] w_x, w_y;
  logic          r_hs, r_vs, r_de, r_border, r_fetch;
  logic [CW-1:0] r_x, r_y;

  timing_axis #(
    .CW(CW), .SYNC_LEN(H_SYNC), .BP_LEN(H_BP), .LT_LEN(H_LB),
    .ADDR_LEN(H_ADDR), .RB_LEN(H_RB), .FP_LEN(H_FP)
  ) u_h_axis (
    .clk(clk), .rst(rst), .i_en(en), .i_clr(restart),
    .o_cnt(w_h_cnt), .o_cnt_nxt_c(w_h_nxt), .o_state_nxt_c(w_h_state),
    .o_sync_c(w_h_sync), .o_active_c(w_h_act), .o_wrap_c(w_h_wrap)
  );

  // Vertical advances on the horizontal wrap tick.
  timing_axis #(
    .CW(CW), .SYNC_LEN(V_SYNC), .BP_LEN(V_BP), .LT_LEN(V_TB),
    .ADDR_LEN(V_ADDR), .RB_LEN(V_BB), .FP_LEN(V_FP)
  ) u_v_axis (
    .clk(clk), .rst(rst), .i_en(w_h_wrap), .i_clr(restart),
    .o_cnt(w_v_cnt), .o_cnt_nxt_c(w_v_nxt), .o_state_nxt_c(w_v_state),
    .o_sync_c(w_v_sync), .o_active_c(w_v_act), .o_wrap_c(w_v_wrap)
  );

  // Output decode of the position about to become current.
  always_comb begin
    w_h_vis  = w_h_state inside {BORDER_LT, ADDR, BORDER_RB};
    w_v_vis  = w_v_state inside {BORDER_LT, ADDR, BORDER_RB};
    w_de     = w_h_act && w_v_act;
    w_border = w_h_vis && w_v_vis && !w_de;
    w_fetch  = w_v_act && (w_h_nxt >= CW'(F_START)) && (w_h_nxt < CW'(F_END));
    w_x      = w_fetch ? (w_h_nxt - CW'(F_START)) : '0;
    w_y      = w_fetch ? (w_v_nxt - CW'(VA)) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hs     <= HS_POL;
      r_vs     <= VS_POL;
      r_de     <= 1'b0;
      r_border <= 1'b0;
      r_fetch  <= 1'b0;
      r_x      <= '0;
      r_y      <= '0;
    end else begin
      r_hs     <= w_h_sync ? HS_POL : ~HS_POL;
      r_vs     <= w_v_sync ? VS_POL : ~VS_POL;
      r_de     <= w_de;
      r_border <= w_border;
      r_fetch  <= w_fetch;
      r_x      <= w_x;
      r_y      <= w_y;
    end
  end

  assign hs          = r_hs;
  assign vs          = r_vs;
  assign de          = r_de;
  assign border      = r_border;
  assign fetch_en    = r_fetch;
  assign x           = r_x;
  assign y           = r_y;
  assign line_start  = en && !restart && (w_h_cnt == '0);
  assign frame_start = en && !restart && (w_h_cnt == '0) && (w_v_cnt == '0);

`ifdef DISPLAY_TIMING_FRAME_CNT_EN
  logic [15:0] r_frame_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame_cnt <= '0;
    end else if (w_v_wrap) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign frame_count = r_frame_cnt;
`else
  logic w_unused_v_wrap;
  assign w_unused_v_wrap = w_v_wrap;
`endif

endmodule

// File: doc/display_timing_generator.md
Name: display_timing_generator

Overview:
Parametrised VGA/DVI raster timing generator, the successor to the fixed 640x480 timing controller. Horizontal and vertical timings, sync polarities, frame-buffer fetch lead and counter width are all parameters. Adds a pixel clock-enable, a synchronous frame restart, border/blank flags, and line/frame start pulses. Sits between the pixel clock domain and the frame-buffer reader / VGA output stage.

Parameters:
CW, 11, width of h/v counters and x/y outputs; elaboration error if clog2(H_TOTAL) or clog2(V_TOTAL) exceeds CW.
H_SYNC, 96, hsync width, pixel clocks.
H_BP, 40, horizontal back porch.
H_LB, 8, left border.
H_ADDR, 640, addressable pixels per line.
H_RB, 8, right border.
H_FP, 8, horizontal front porch.
V_SYNC, 2; V_BP, 25; V_TB, 8; V_ADDR, 480; V_BB, 8; V_FP, 2: vertical equivalents, in lines.
HS_POL, 0, hsync active level.
VS_POL, 0, vsync active level.
FETCH_LEAD, 1, cycles by which fetch_en/x/y lead de; legal range 0..H_SYNC+H_BP+H_LB, elaboration error otherwise.

Ports:
clk  in  1  pixel-domain clock
rst  in  1  asynchronous, active-high reset
en  in  1  pixel advance enable; position advances only when high
restart  in  1  synchronous frame restart
hs  out  1  horizontal sync, registered
vs  out  1  vertical sync, registered
de  out  1  addressable area (both axes in ADDR), registered
border  out  1  in border region of either axis and not blanked
fetch_en  out  1  frame-buffer read strobe, FETCH_LEAD cycles ahead of de
x  out  CW  fetch column, valid while fetch_en, else 0
y  out  CW  fetch row, valid while fetch_en, else 0
line_start  out  1  en && h==0
frame_start  out  1  en && h==0 && v==0

Behaviour:
- Derived constants: H_TOTAL = sum of H_* durations (800 default); V_TOTAL likewise (525). HA = H_SYNC+H_BP+H_LB (144); VA = V_SYNC+V_BP+V_TB (35).
- Position (h,v) is the displayed pixel: h in 0..H_TOTAL-1, v in 0..V_TOTAL-1.
- Advance rule, evaluated each clk:
  - restart=1: next (0,0). Overrides en.
  - else en=1: h increments; at h=H_TOTAL-1, h wraps to 0 and v increments; v wraps to 0 after V_TOTAL-1.
  - else: hold position. All registered outputs hold.
- Registered outputs (hs, vs, de, border, fetch_en, x, y) reflect the current position in the same cycle; glitch-free. The implementation keeps its counters one step ahead internally.
- hs = HS_POL when h<H_SYNC, else ~HS_POL. vs = VS_POL when v<V_SYNC, else ~VS_POL.
- de = (HA <= h < HA+H_ADDR) && (VA <= v < VA+V_ADDR).
- border = in left/top or right/bottom border band of either axis, and in neither axis's sync/porch, and !de.
- fetch_en = (HA-FETCH_LEAD <= h < HA+H_ADDR-FETCH_LEAD) && vertical active. x = h-HA+FETCH_LEAD; y = v-VA. Both are 0 outside fetch_en. The fetch window never crosses a line boundary.
- Axis state per counter: SYNC -> BP -> BORDER_LT -> ADDR -> BORDER_RB -> FP -> SYNC. Transitions occur on segment boundaries. A zero-length segment is skipped.
- line_start and frame_start are combinational with en. They are high for exactly one en-qualified cycle per line/frame, and low while restart=1.
- Reset (async assert, sync release): position (0,0). hs=HS_POL, vs=VS_POL, de=0, border=0, fetch_en=0, x=0, y=0.
- Reset or restart mid-frame: the partial frame is abandoned, with no pulse for the abandoned frame.

Optional Feature:
DISPLAY_TIMING_FRAME_CNT_EN.
- Defined: extra output frame_count[15:0]. Reset value 0. Increments when position wraps (H_TOTAL-1,V_TOTAL-1)->(0,0) with en=1. Wraps 65535->0. Not incremented by restart.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Package display_timing_pkg:
  - axis_state_e enum (SYNC, BP, BORDER_LT, ADDR, BORDER_RB, FP).
  - Default 640x480@60 timing constants.
  - Function returning axis total from segment lengths.
- Sub-module timing_axis, instantiated twice (h and v):
  - Counter with en/clear and terminal-count wrap.
  - Outputs: state, sync flag, active flag, wrap tick.

Test Plan:
- Defaults, en=1, release reset: hs low for h=0..95, high at h=96; line_start every 800 cycles; frame_start every 420000 cycles.
- Defaults: first fetch_en at (h=143,v=35) with x=0,y=0. de first high at h=144. Last fetch x=639 at h=782; de low at h=784.
- en toggled 1/0 alternately: every output holds during en=0; line period becomes 1600 clk; pulses stay single-cycle.
- restart at (h=500,v=200): next cycle position (0,0), hs=vs=0, no frame_start in restart cycle, frame_start one cycle later.
- Async rst asserted mid-ADDR: outputs take reset values immediately; with DISPLAY_TIMING_FRAME_CNT_EN, frame_count=0, then 1 after first full frame.
- FETCH_LEAD=0, HS_POL=1, V_TB=0: fetch_en coincides with de; hs high during sync; vertical BORDER_LT skipped, so v=27 is ADDR.
